// File: rtl/key_event.sv
`default_nettype none
// ============================================================================
// Module  : key_event
// Brief   : Turns a debounced button level into press, release, long-press,
//           hold and auto-repeat events, plus a wrapping event counter.
// Revision: 1.0  initial release
// ============================================================================
module key_event #(
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CNT_W    = 27,
  parameter int EVT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             press,
  output logic             release_pulse,
  output logic             long,
  output logic             hold,
  output logic             rpt,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DOWN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long          <= 1'b0;
      hold          <= 1'b0;
      rpt           <= 1'b0;
      evt_cnt       <= '0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long          <= 1'b0;
      rpt           <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (x) begin
            press   <= 1'b1;
            cnt     <= '0;
            evt_cnt <= evt_cnt + EVT_W'(1);
            state   <= ST_DOWN;
          end
        end

        // Release is checked first so it wins over the long threshold.
        ST_DOWN: begin
          if (!x) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            state         <= ST_IDLE;
          end else if (cnt == LONG_LAST) begin
            long  <= 1'b1;
            hold  <= 1'b1;
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (!x) begin
            release_pulse <= 1'b1;
            hold          <= 1'b0;
            cnt           <= '0;
            state         <= ST_IDLE;
          end else if (cnt == REP_LAST) begin
            rpt     <= 1'b1;
            evt_cnt <= evt_cnt + EVT_W'(1);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          hold  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
